// File: rtl/dac_sample_fifo.sv
`default_nettype none
// ============================================================================
// Module      : dac_sample_fifo
// Description : Elastic sample buffer between the ANC core output and the
//               DAC-side I2S transmitter. Absorbs jitter between the core's
//               compute-complete strobes and the transmitter's frame-rate
//               requests. Primes to PREFILL entries before playback and
//               re-primes after an underflow. Every request is answered with
//               exactly one out_valid pulse one cycle later.
// Revision    : 1.0 - initial release
// ----------------------------------------------------------------------------
// Parameters:
//   DEPTH     FIFO entries (power of two, >= 4)
//   PREFILL   occupancy needed to start playback (1..DEPTH)
//   UNF_ZERO  1: answer a starved request with 0
//             0: answer a starved request with the last sample sent
// Ports:
//   clk, rst     system clock, synchronous active-high reset
//   in_sample    signed sample from the ANC core
//   in_valid     1-cycle write strobe paired with in_sample
//   out_req      1-cycle request from the I2S transmitter
//   out_sample   sample to the transmitter, held between pulses
//   out_valid    1-cycle pulse, one cycle after each out_req
//   level        current occupancy (0..DEPTH)
//   full, empty  level == DEPTH / level == 0
//   overflow     1-cycle pulse: an incoming write was dropped
//   underflow    1-cycle pulse: a request was served while starved in RUN
// Optional feature (macro DAC_FIFO_STATS_EN):
//   stat_clr     zeroes both event counters
//   ovf_cnt      saturating count of dropped writes
//   unf_cnt      saturating count of underflows
// ============================================================================
module dac_sample_fifo #(
  parameter int DEPTH    = 8,
  parameter int PREFILL  = 4,
  parameter int UNF_ZERO = 0
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [15:0]              in_sample,
  input  logic                     in_valid,
  input  logic                     out_req,
  output logic [15:0]              out_sample,
  output logic                     out_valid,
  output logic [$clog2(DEPTH):0]   level,
  output logic                     full,
  output logic                     empty,
  output logic                     overflow,
  output logic                     underflow
`ifdef DAC_FIFO_STATS_EN
  ,
  input  logic                     stat_clr,
  output logic [15:0]              ovf_cnt,
  output logic [15:0]              unf_cnt
`endif
);

  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;

  localparam logic [LW-1:0] c_DEPTH_L   = LW'(DEPTH);
  localparam logic [LW-1:0] c_PREFILL_L = LW'(PREFILL);
  localparam logic [AW-1:0] c_PTR_ONE   = AW'(1);
  localparam logic [LW-1:0] c_LVL_ONE   = LW'(1);

  typedef enum logic [0:0] {
    ST_FILL = 1'b0,
    ST_RUN  = 1'b1
  } state_t;

  // --------------------------------------------------------------------------
  // Storage and registered state
  // --------------------------------------------------------------------------
  logic [15:0]   r_mem [DEPTH];
  logic [AW-1:0] r_wr_ptr;
  logic [AW-1:0] r_rd_ptr;
  logic [LW-1:0] r_level;
  logic          r_full;
  logic          r_empty;
  state_t        r_state;
  logic [15:0]   r_out_sample;
  logic [15:0]   r_last;
  logic          r_out_valid;
  logic          r_overflow;
  logic          r_underflow;

  // --------------------------------------------------------------------------
  // Combinational decode
  // --------------------------------------------------------------------------
  state_t        w_state_nxt;
  logic          w_pop;
  logic          w_push;
  logic          w_drop;
  logic          w_unf;
  logic [LW-1:0] w_level_nxt;

  always_comb begin
    w_state_nxt = r_state;
    w_pop       = 1'b0;
    w_push      = 1'b0;
    w_drop      = 1'b0;
    w_unf       = 1'b0;
    w_level_nxt = r_level;

    // Only RUN with data consumes an entry; FILL answers every request from
    // the held sample (or zero) without touching the buffer.
    w_pop = (r_state == ST_RUN) && out_req && !r_empty;

    // A starved request in RUN is the only underflow; starvation in FILL is
    // the expected priming condition and stays silent.
    w_unf = (r_state == ST_RUN) && out_req && r_empty;

    // A pop in the same cycle frees a slot, so a write at full still lands.
    w_push = in_valid && (!r_full || w_pop);
    w_drop = in_valid && r_full && !w_pop;

    if (w_push && !w_pop) begin
      w_level_nxt = r_level + c_LVL_ONE;
    end else if (w_pop && !w_push) begin
      w_level_nxt = r_level - c_LVL_ONE;
    end

    case (r_state)
      ST_FILL: begin
        // Decided on the registered level, so RUN starts one cycle after the
        // threshold is visible on the level output.
        if (r_level >= c_PREFILL_L) begin
          w_state_nxt = ST_RUN;
        end
      end
      ST_RUN: begin
        if (w_unf) begin
          w_state_nxt = ST_FILL;
        end
      end
      default: w_state_nxt = ST_FILL;
    endcase
  end

  // --------------------------------------------------------------------------
  // Sample memory (contents are don't-care after reset, so no reset branch)
  // --------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem[r_wr_ptr] <= in_sample;
    end
  end

  // --------------------------------------------------------------------------
  // Control registers
  // --------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state  <= ST_FILL;
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_level  <= '0;
      r_full   <= 1'b0;
      r_empty  <= 1'b1;
    end else begin
      r_state <= w_state_nxt;
      r_level <= w_level_nxt;
      r_full  <= (w_level_nxt == c_DEPTH_L);
      r_empty <= (w_level_nxt == '0);
      if (w_push) begin
        r_wr_ptr <= r_wr_ptr + c_PTR_ONE;
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + c_PTR_ONE;
      end
    end
  end

  // --------------------------------------------------------------------------
  // Output sample path
  // --------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      r_out_sample <= '0;
      r_last       <= '0;
      r_out_valid  <= 1'b0;
      r_overflow   <= 1'b0;
      r_underflow  <= 1'b0;
    end else begin
      r_out_valid <= out_req;
      r_overflow  <= w_drop;
      r_underflow <= w_unf;
      if (w_pop) begin
        r_out_sample <= r_mem[r_rd_ptr];
        r_last       <= r_mem[r_rd_ptr];
      end else if (out_req) begin
        // Starved answer: the held sample is not updated, so repeated
        // starvation keeps replaying the same last real sample.
        r_out_sample <= (UNF_ZERO != 0) ? 16'h0000 : r_last;
      end
    end
  end

  assign out_sample = r_out_sample;
  assign out_valid  = r_out_valid;
  assign level      = r_level;
  assign full       = r_full;
  assign empty      = r_empty;
  assign overflow   = r_overflow;
  assign underflow  = r_underflow;

`ifdef DAC_FIFO_STATS_EN
  // --------------------------------------------------------------------------
  // Event counters. They count the event in the cycle it happens, so each
  // count lands on the same edge as the matching pulse. A clear coinciding
  // with an event restarts the count at 1 rather than losing the event.
  // --------------------------------------------------------------------------
  logic [15:0] r_ovf_cnt;
  logic [15:0] r_unf_cnt;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_ovf_cnt <= '0;
      r_unf_cnt <= '0;
    end else if (stat_clr) begin
      r_ovf_cnt <= {15'd0, w_drop};
      r_unf_cnt <= {15'd0, w_unf};
    end else begin
      if (w_drop && (r_ovf_cnt != 16'hFFFF)) begin
        r_ovf_cnt <= r_ovf_cnt + 16'd1;
      end
      if (w_unf && (r_unf_cnt != 16'hFFFF)) begin
        r_unf_cnt <= r_unf_cnt + 16'd1;
      end
    end
  end

  assign ovf_cnt = r_ovf_cnt;
  assign unf_cnt = r_unf_cnt;
`endif

endmodule
`default_nettype wire
